mips_multicycle_ctrl: RTL and testbench

Moore-style main control FSM for the multicycle MIPS datapath. It sequences one shared ALU, one unified memory port and the register file across fetch, decode, execute, memory and write-back cycles. Each cycle it drives the 3-bit `alu_op_o` consumed by `ALU_Control`, plus all mux selects and write enables. It stalls on a memory-ready handshake and traps on unsupported opcodes.

---
 rtl/mips_ctrl_pkg.sv | 78 +++++++
 rtl/mips_multicycle_ctrl_if.sv | 38 +++
 rtl/mips_ctrl_out_decode.sv | 88 ++++++++
 rtl/mips_multicycle_ctrl.sv | 95 +++++++++
 tb/tb_mips_multicycle_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and its ALU_Control peer.
// Holds opcodes, ALU operation codes, state encodings, mux selects and the control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU_Control decodes these; SUB must stay 010 on both sides.
    localparam logic [2:0] ALU_OP_RTYPE = 3'b111;
    localparam logic [2:0] ALU_OP_ADD   = 3'b100;
    localparam logic [2:0] ALU_OP_OR    = 3'b001;
    localparam logic [2:0] ALU_OP_SUB   = 3'b010;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_ILLEGAL  = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_word_t;

    // Dispatch target out of DECODE; unknown opcodes fall into the trap state.
    function automatic state_t decode_target(input logic [5:0] op);
        state_t tgt;
        case (op)
            OP_RTYPE:      tgt = ST_EXEC_R;
            OP_ADDI:       tgt = ST_EXEC_I;
            OP_ORI:        tgt = ST_EXEC_I;
            OP_LW, OP_SW:  tgt = ST_MEM_ADDR;
            OP_BEQ:        tgt = ST_BRANCH;
            OP_J:          tgt = ST_JUMP;
            default:       tgt = ST_ILLEGAL;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the main FSM (master) and the multicycle datapath (slave).
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       pc_write_cond_o;
    logic [1:0] pc_source_o;
    logic       i_or_d_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic       ext_zero_o;
    logic [2:0] alu_op_o;
    logic       instr_done_o;
    logic       illegal_o;
    logic [3:0] state_o;

    modport master (
        input  opcode_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o, mem_read_o,
               mem_write_o, ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
               alu_src_a_o, alu_src_b_o, ext_zero_o, alu_op_o, instr_done_o,
               illegal_o, state_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, pc_source_o, i_or_d_o, mem_read_o,
               mem_write_o, ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
               alu_src_a_o, alu_src_b_o, ext_zero_o, alu_op_o, instr_done_o,
               illegal_o, state_o
    );
endinterface

// File: rtl/mips_ctrl_out_decode.sv
// Moore control-word decoder: state (plus opcode in EXEC_I, ready in the memory
// states) to every datapath select and enable.
module mips_ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       ready,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_OP_ADD;
        case (state)
            ST_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed on ready.
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = ready;
                ctrl.pc_write  = ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SH2;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = ready;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_OP_RTYPE;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                if (opcode == OP_ORI) begin
                    ctrl.alu_op   = ALU_OP_OR;
                    ctrl.ext_zero = 1'b1;
                end
            end
            ST_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state register, next-state
// logic and reset gating of every write/strobe output.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    state_t     state_reg;
    state_t     state_next;
    ctrl_word_t ctrl;
    logic       ready;

    assign ready = MEM_WAIT_EN ? bus.mem_ready_i : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH:    state_next = ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:   state_next = decode_target(bus.opcode_i);
            ST_MEM_ADDR: begin
                if (bus.opcode_i == OP_LW) begin
                    state_next = ST_MEM_RD;
                end else if (bus.opcode_i == OP_SW) begin
                    state_next = ST_MEM_WR;
                end else begin
                    state_next = ST_ILLEGAL;
                end
            end
            ST_MEM_RD:   state_next = ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   state_next = ST_FETCH;
            ST_MEM_WR:   state_next = ready ? ST_FETCH : ST_MEM_WR;
            ST_EXEC_R:   state_next = ST_R_WB;
            ST_R_WB:     state_next = ST_FETCH;
            ST_EXEC_I:   state_next = ST_I_WB;
            ST_I_WB:     state_next = ST_FETCH;
            ST_BRANCH:   state_next = ST_FETCH;
            ST_JUMP:     state_next = ST_FETCH;
            ST_ILLEGAL:  state_next = ST_ILLEGAL;
            default:     state_next = ST_ILLEGAL;
        endcase
    end

    mips_ctrl_out_decode u_out_decode (
        .state  (state_reg),
        .opcode (bus.opcode_i),
        .ready  (ready),
        .ctrl   (ctrl)
    );

    // Strobes are cut combinationally by reset so nothing writes while it is held.
    logic [5:0] strobe_raw;
    logic [5:0] strobe_gated;

    assign strobe_raw = {ctrl.pc_write, ctrl.pc_write_cond, ctrl.ir_write,
                         ctrl.reg_write, ctrl.mem_write, ctrl.mem_read};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_strobe_gate
            assign strobe_gated[gi] = strobe_raw[gi] & reset;
        end
    endgenerate

    assign bus.pc_write_o      = strobe_gated[5];
    assign bus.pc_write_cond_o = strobe_gated[4];
    assign bus.ir_write_o      = strobe_gated[3];
    assign bus.reg_write_o     = strobe_gated[2];
    assign bus.mem_write_o     = strobe_gated[1];
    assign bus.mem_read_o      = strobe_gated[0];

    assign bus.pc_source_o  = ctrl.pc_source;
    assign bus.i_or_d_o     = ctrl.i_or_d;
    assign bus.reg_dst_o    = ctrl.reg_dst;
    assign bus.mem_to_reg_o = ctrl.mem_to_reg;
    assign bus.alu_src_a_o  = ctrl.alu_src_a;
    assign bus.alu_src_b_o  = ctrl.alu_src_b;
    assign bus.ext_zero_o   = ctrl.ext_zero;
    assign bus.alu_op_o     = ctrl.alu_op;
    assign bus.instr_done_o = ctrl.instr_done;
    assign bus.illegal_o    = ctrl.illegal;
    assign bus.state_o      = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: expected per-cycle control words are
// queued as each cycle is driven and popped when the outputs are sampled.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } word_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    word_t sb[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected words, one per state, taken from the control table.
    function automatic word_t w_base(input int st);
        word_t w = '0;
        w.state  = st[3:0];
        w.alu_op = 3'b100;
        return w;
    endfunction

    function automatic word_t x_rst();
        word_t w = w_base(0);
        w.alu_src_b = 2'b01;
        return w;
    endfunction

    function automatic word_t x_fetch(input logic rdy);
        word_t w = w_base(0);
        w.mem_read = 1'b1; w.alu_src_b = 2'b01;
        w.ir_write = rdy;  w.pc_write  = rdy;
        return w;
    endfunction

    function automatic word_t x_decode();
        word_t w = w_base(1);
        w.alu_src_b = 2'b11;
        return w;
    endfunction

    function automatic word_t x_maddr();
        word_t w = w_base(2);
        w.alu_src_a = 1'b1; w.alu_src_b = 2'b10;
        return w;
    endfunction

    function automatic word_t x_mrd();
        word_t w = w_base(3);
        w.i_or_d = 1'b1; w.mem_read = 1'b1;
        return w;
    endfunction

    function automatic word_t x_mwb();
        word_t w = w_base(4);
        w.reg_write = 1'b1; w.mem_to_reg = 1'b1; w.instr_done = 1'b1;
        return w;
    endfunction

    function automatic word_t x_mwr(input logic rdy);
        word_t w = w_base(5);
        w.i_or_d = 1'b1; w.mem_write = 1'b1; w.instr_done = rdy;
        return w;
    endfunction

    function automatic word_t x_exr();
        word_t w = w_base(6);
        w.alu_src_a = 1'b1; w.alu_op = 3'b111;
        return w;
    endfunction

    function automatic word_t x_rwb();
        word_t w = w_base(7);
        w.reg_write = 1'b1; w.reg_dst = 1'b1; w.instr_done = 1'b1;
        return w;
    endfunction

    function automatic word_t x_exi(input logic ori);
        word_t w = w_base(8);
        w.alu_src_a = 1'b1; w.alu_src_b = 2'b10;
        if (ori) begin
            w.alu_op = 3'b001; w.ext_zero = 1'b1;
        end
        return w;
    endfunction

    function automatic word_t x_iwb();
        word_t w = w_base(9);
        w.reg_write = 1'b1; w.instr_done = 1'b1;
        return w;
    endfunction

    function automatic word_t x_br();
        word_t w = w_base(10);
        w.alu_src_a = 1'b1; w.alu_op = 3'b010; w.pc_write_cond = 1'b1;
        w.pc_source = 2'b01; w.instr_done = 1'b1;
        return w;
    endfunction

    function automatic word_t x_jmp();
        word_t w = w_base(11);
        w.pc_write = 1'b1; w.pc_source = 2'b10; w.instr_done = 1'b1;
        return w;
    endfunction

    function automatic word_t x_ill();
        word_t w = w_base(12);
        w.illegal = 1'b1;
        return w;
    endfunction

    function automatic word_t sample();
        word_t o;
        o.state         = bus.state_o;
        o.pc_write      = bus.pc_write_o;
        o.pc_write_cond = bus.pc_write_cond_o;
        o.pc_source     = bus.pc_source_o;
        o.i_or_d        = bus.i_or_d_o;
        o.mem_read      = bus.mem_read_o;
        o.mem_write     = bus.mem_write_o;
        o.ir_write      = bus.ir_write_o;
        o.reg_write     = bus.reg_write_o;
        o.reg_dst       = bus.reg_dst_o;
        o.mem_to_reg    = bus.mem_to_reg_o;
        o.alu_src_a     = bus.alu_src_a_o;
        o.alu_src_b     = bus.alu_src_b_o;
        o.ext_zero      = bus.ext_zero_o;
        o.alu_op        = bus.alu_op_o;
        o.instr_done    = bus.instr_done_o;
        o.illegal       = bus.illegal_o;
        return o;
    endfunction

    task automatic check_head(input string tag);
        word_t obs = sample();
        word_t exp;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            exp = sb.pop_front();
            total++;
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
            $display("cycle %s state=%0d word=%h", tag, obs.state, obs);
        end
    endtask

    // One clock cycle: drive ready, queue the expectation, sample mid-cycle.
    task automatic cyc(input string tag, input logic rdy, input word_t exp);
        bus.mem_ready_i = rdy;
        sb.push_back(exp);
        @(negedge clk);
        check_head(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.opcode_i    = 6'b000000;
        bus.mem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 1'b1, x_rst());
        reset = 1'b1;

        // ADD, ready held high
        bus.opcode_i = 6'b000000;
        cyc("add_f",  1'b1, x_fetch(1'b1));
        cyc("add_d",  1'b1, x_decode());
        cyc("add_ex", 1'b1, x_exr());
        cyc("add_wb", 1'b1, x_rwb());

        // LW with 2 fetch waits and 3 read waits: 10 cycles
        bus.opcode_i = 6'b100011;
        cyc("lw_f0",  1'b0, x_fetch(1'b0));
        cyc("lw_f1",  1'b0, x_fetch(1'b0));
        cyc("lw_f2",  1'b1, x_fetch(1'b1));
        cyc("lw_d",   1'b0, x_decode());
        cyc("lw_ma",  1'b1, x_maddr());
        cyc("lw_r0",  1'b0, x_mrd());
        cyc("lw_r1",  1'b0, x_mrd());
        cyc("lw_r2",  1'b0, x_mrd());
        cyc("lw_r3",  1'b1, x_mrd());
        cyc("lw_wb",  1'b0, x_mwb());

        // ORI
        bus.opcode_i = 6'b001101;
        cyc("ori_f",  1'b1, x_fetch(1'b1));
        cyc("ori_d",  1'b1, x_decode());
        cyc("ori_ex", 1'b0, x_exi(1'b1));
        cyc("ori_wb", 1'b1, x_iwb());

        // ADDI
        bus.opcode_i = 6'b001000;
        cyc("addi_f",  1'b1, x_fetch(1'b1));
        cyc("addi_d",  1'b0, x_decode());
        cyc("addi_ex", 1'b1, x_exi(1'b0));
        cyc("addi_wb", 1'b0, x_iwb());

        // SW, no waits
        bus.opcode_i = 6'b101011;
        cyc("sw_f",  1'b1, x_fetch(1'b1));
        cyc("sw_d",  1'b1, x_decode());
        cyc("sw_ma", 1'b0, x_maddr());
        cyc("sw_w",  1'b1, x_mwr(1'b1));

        // BEQ, ready low where it must be ignored
        bus.opcode_i = 6'b000100;
        cyc("beq_f",  1'b1, x_fetch(1'b1));
        cyc("beq_d",  1'b0, x_decode());
        cyc("beq_br", 1'b0, x_br());

        // J
        bus.opcode_i = 6'b000010;
        cyc("j_f",   1'b1, x_fetch(1'b1));
        cyc("j_d",   1'b1, x_decode());
        cyc("j_jmp", 1'b1, x_jmp());

        // Illegal opcode traps and holds
        bus.opcode_i = 6'b111111;
        cyc("ill_f", 1'b1, x_fetch(1'b1));
        cyc("ill_d", 1'b1, x_decode());
        for (int i = 0; i < 22; i++) begin
            cyc("ill_hold", 1'($urandom_range(0, 1)), x_ill());
        end
        reset = 1'b0;
        cyc("ill_rst", 1'b1, x_rst());
        reset = 1'b1;

        bus.opcode_i = 6'b000000;
        cyc("add2_f",  1'b1, x_fetch(1'b1));
        cyc("add2_d",  1'b1, x_decode());
        cyc("add2_ex", 1'b1, x_exr());
        cyc("add2_wb", 1'b1, x_rwb());

        // SW stalled in MEM_WR, then reset asserted mid-cycle
        bus.opcode_i = 6'b101011;
        cyc("sws_f",  1'b1, x_fetch(1'b1));
        cyc("sws_d",  1'b1, x_decode());
        cyc("sws_ma", 1'b1, x_maddr());
        cyc("sws_w0", 1'b0, x_mwr(1'b0));
        bus.mem_ready_i = 1'b0;
        sb.push_back(x_mwr(1'b0));
        @(negedge clk);
        check_head("sws_w1");
        #2;
        reset = 1'b0;
        #1;
        total++;
        assert ((bus.mem_write_o === 1'b0) && (bus.state_o === 4'd0)) else begin
            bad++;
            $error("FAIL async_rst mem_write=%b state=%0d expected mem_write=0 state=0",
                   bus.mem_write_o, bus.state_o);
        end
        $display("cycle async_rst mem_write=%b state=%0d", bus.mem_write_o, bus.state_o);
        @(posedge clk);
        #1;
        cyc("sws_rst", 1'b1, x_rst());
        reset = 1'b1;

        bus.opcode_i = 6'b000010;
        cyc("j2_f",   1'b0, x_fetch(1'b0));
        cyc("j2_f1",  1'b1, x_fetch(1'b1));
        cyc("j2_d",   1'b1, x_decode());
        cyc("j2_jmp", 1'b1, x_jmp());

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
